// File: rtl/gfx_pkg.sv
// Shared definitions for the layer compositor slice.
// Provides default colour geometry, channel slice offsets ({R,G,B} with R in
// the high bits), the default transparent key colour and the index reported
// when the background wins.
package gfx_pkg;
    localparam int COLOR_W_DEF = 8;
    localparam int RGB_W       = 3 * COLOR_W_DEF;

    localparam logic [RGB_W-1:0] KEY_RGB_DEF = 24'hFF00FF;
    localparam int               BG_IDX      = 0;

    // Channel LSB offsets inside an {R,G,B} word for a given channel width.
    function automatic int r_lsb(input int cw);
        return 2 * cw;
    endfunction

    function automatic int g_lsb(input int cw);
        return cw;
    endfunction

    function automatic int b_lsb(input int cw);
        return 0;
    endfunction
endpackage

// File: rtl/gfx_layer_compositor_if.sv
// Pixel bus between the sprite generators / frame timing (master) and the
// layer compositor (slave).
//   i_pix_valid, i_v_sync        : pixel qualifier and vertical sync level
//   i_layer_hit/en, i_layer_rgb  : per-layer hit, enable and packed colour
//   i_bg_rgb, i_key_en, i_key_rgb: background and colour-key controls
//   o_red/o_green/o_blue, o_valid, o_top_idx, o_bg_sel : composited pixel
//   o_collision_mask, o_player_collide, o_frame_done   : frame report
interface gfx_layer_compositor_if #(
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_W    = 8,
    parameter int IDX_W      = 3
);
    logic                              i_pix_valid;
    logic                              i_v_sync;
    logic [NUM_LAYERS-1:0]             i_layer_hit;
    logic [NUM_LAYERS*3*COLOR_W-1:0]   i_layer_rgb;
    logic [3*COLOR_W-1:0]              i_bg_rgb;
    logic [NUM_LAYERS-1:0]             i_layer_en;
    logic                              i_key_en;
    logic [3*COLOR_W-1:0]              i_key_rgb;

    logic [COLOR_W-1:0]                o_red;
    logic [COLOR_W-1:0]                o_green;
    logic [COLOR_W-1:0]                o_blue;
    logic                              o_valid;
    logic [IDX_W-1:0]                  o_top_idx;
    logic                              o_bg_sel;
    logic [NUM_LAYERS-1:0]             o_collision_mask;
    logic                              o_player_collide;
    logic                              o_frame_done;

    modport master (
        output i_pix_valid, i_v_sync, i_layer_hit, i_layer_rgb, i_bg_rgb,
               i_layer_en, i_key_en, i_key_rgb,
        input  o_red, o_green, o_blue, o_valid, o_top_idx, o_bg_sel,
               o_collision_mask, o_player_collide, o_frame_done
    );

    modport slave (
        input  i_pix_valid, i_v_sync, i_layer_hit, i_layer_rgb, i_bg_rgb,
               i_layer_en, i_key_en, i_key_rgb,
        output o_red, o_green, o_blue, o_valid, o_top_idx, o_bg_sel,
               o_collision_mask, o_player_collide, o_frame_done
    );
endinterface

// File: rtl/gfx_prio_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
//   i_req : request vector, bit 0 highest priority
//   o_idx : index of the winning request (0 when none)
//   o_any : at least one request is set
module gfx_prio_encoder #(
    parameter int NUM_LAYERS = 8,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_LAYERS-1:0] i_req,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_any
);
    // Scan from the lowest-priority end so the lowest set index is the last
    // assignment and therefore wins.
    always_comb begin
        o_idx = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (i_req[k]) o_idx = IDX_W'(k);
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/gfx_layer_compositor.sv
// Two-stage sprite layer compositor with per-frame collision reporting.
// Stage 1 qualifies each layer hit (enable mask, colour key) and registers
// the pixel; stage 2 picks the highest-priority layer (index 0 first) or
// the background. Overlaps of two or more qualified layers are accumulated
// per frame and reported on each rising edge of v_sync.
//   i_clk, i_rst_n : pixel clock, asynchronous active-low reset
//   bus            : pixel bus (slave side), see gfx_layer_compositor_if
module gfx_layer_compositor
    import gfx_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int IDX_W      = 3,
    parameter int PLAYER_IDX = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    gfx_layer_compositor_if.slave  bus
);
    localparam int RGB_L = 3 * COLOR_W;
    localparam int R_LSB = r_lsb(COLOR_W);
    localparam int G_LSB = g_lsb(COLOR_W);
    localparam int B_LSB = b_lsb(COLOR_W);

    // Stage 1 registers
    logic [NUM_LAYERS-1:0]       r_s1_q;
    logic [NUM_LAYERS*RGB_L-1:0] r_s1_rgb;
    logic [RGB_L-1:0]            r_s1_bg;
    logic                        r_s1_vld;
    logic                        r_s1_vs;
    logic                        r_s1_vs_prev;

    // Stage 2 registers
    logic [RGB_L-1:0]            r_s2_rgb;
    logic [IDX_W-1:0]            r_s2_idx;
    logic                        r_s2_bg;
    logic                        r_s2_vld;

    // Frame report
    logic [NUM_LAYERS-1:0]       r_acc;
    logic [NUM_LAYERS-1:0]       r_mask;
    logic                        r_player;
    logic                        r_done;

    logic [NUM_LAYERS-1:0]       w_q;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_any;
    logic [RGB_L-1:0]            w_win_rgb;
    logic                        w_multi;
    logic [NUM_LAYERS-1:0]       w_contrib;
    logic [NUM_LAYERS-1:0]       w_report;
    logic                        w_frame_close;

    // A layer only counts if hit, enabled and not showing the key colour.
    always_comb begin
        w_q = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            w_q[k] = bus.i_layer_hit[k] & bus.i_layer_en[k]
                   & ~(bus.i_key_en & (bus.i_layer_rgb[k*RGB_L +: RGB_L] == bus.i_key_rgb));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_q       <= '0;
            r_s1_rgb     <= '0;
            r_s1_bg      <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s1_vs_prev <= 1'b0;
        end else begin
            r_s1_q       <= w_q;
            r_s1_rgb     <= bus.i_layer_rgb;
            r_s1_bg      <= bus.i_bg_rgb;
            r_s1_vld     <= bus.i_pix_valid;
            r_s1_vs      <= bus.i_v_sync;
            r_s1_vs_prev <= r_s1_vs;
        end
    end

    gfx_prio_encoder #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_prio (
        .i_req (r_s1_q),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_win_rgb = r_s1_rgb[int'(w_idx)*RGB_L +: RGB_L];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_rgb <= '0;
            r_s2_idx <= '0;
            r_s2_bg  <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_rgb <= w_any ? w_win_rgb : r_s1_bg;
            r_s2_idx <= w_any ? w_idx : IDX_W'(BG_IDX);
            r_s2_bg  <= ~w_any;
            r_s2_vld <= r_s1_vld;
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign w_multi       = (r_s1_q & (r_s1_q - NUM_LAYERS'(1))) != '0;
    assign w_contrib     = (r_s1_vld & w_multi) ? r_s1_q : '0;
    assign w_frame_close = r_s1_vs & ~r_s1_vs_prev;
    // The pixel in the edge cycle still belongs to the frame being closed.
    assign w_report      = r_acc | w_contrib;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mask   <= '0;
            r_player <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_frame_close) begin
            r_acc    <= '0;
            r_mask   <= w_report;
            r_player <= w_report[PLAYER_IDX];
            r_done   <= 1'b1;
        end else begin
            r_acc    <= w_report;
            r_done   <= 1'b0;
        end
    end

    assign bus.o_red            = r_s2_rgb[R_LSB +: COLOR_W];
    assign bus.o_green          = r_s2_rgb[G_LSB +: COLOR_W];
    assign bus.o_blue           = r_s2_rgb[B_LSB +: COLOR_W];
    assign bus.o_valid          = r_s2_vld;
    assign bus.o_top_idx        = r_s2_idx;
    assign bus.o_bg_sel         = r_s2_bg;
    assign bus.o_collision_mask = r_mask;
    assign bus.o_player_collide = r_player;
    assign bus.o_frame_done     = r_done;
endmodule

// File: tb/tb_gfx_layer_compositor.sv
module tb_gfx_layer_compositor;
    import gfx_pkg::*;

    localparam int NL = 8;
    localparam int CW = 8;
    localparam int IW = 3;
    localparam int RW = 3 * CW;
    localparam int PL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gfx_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW), .IDX_W(IW)) bus ();

    gfx_layer_compositor #(
        .NUM_LAYERS (NL),
        .COLOR_W    (CW),
        .IDX_W      (IW),
        .PLAYER_IDX (PL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [RW-1:0] rgb;
        logic [IW-1:0] idx;
        logic          bg;
        logic          vld;
        logic          done;
        logic [NL-1:0] mask;
        logic          player;
        string         tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;

    logic [RW-1:0] lrgb [NL];
    logic [RW-1:0] bg_rgb;
    logic [RW-1:0] key_rgb;
    logic          key_en;

    // Reference frame-report state
    logic [NL-1:0] m_acc    = '0;
    logic [NL-1:0] m_mask   = '0;
    logic          m_player = 1'b0;
    logic          m_prev_vs = 1'b0;

    task automatic check_zero(input string tag);
        checks++;
        assert ({bus.o_red, bus.o_green, bus.o_blue, bus.o_valid, bus.o_top_idx, bus.o_bg_sel,
                 bus.o_collision_mask, bus.o_player_collide, bus.o_frame_done} === '0)
        else begin
            fails++;
            $error("FAIL %s: got rgb=%02h%02h%02h vld=%0b idx=%0d bg=%0b mask=%02h pc=%0b done=%0b, want all 0",
                   tag, bus.o_red, bus.o_green, bus.o_blue, bus.o_valid, bus.o_top_idx, bus.o_bg_sel,
                   bus.o_collision_mask, bus.o_player_collide, bus.o_frame_done);
        end
    endtask

    // Compare the entry pushed two clocks ago against what the DUT shows now.
    task automatic check_front();
        exp_t e;
        logic [RW-1:0] got;
        if (sb.size() < 2) return;
        e = sb.pop_front();
        got = {bus.o_red, bus.o_green, bus.o_blue};
        checks++;
        assert ({got, bus.o_top_idx, bus.o_bg_sel, bus.o_valid} === {e.rgb, e.idx, e.bg, e.vld})
        else begin
            fails++;
            $error("FAIL %s pixel: got rgb=%06h idx=%0d bg=%0b vld=%0b, want rgb=%06h idx=%0d bg=%0b vld=%0b",
                   e.tag, got, bus.o_top_idx, bus.o_bg_sel, bus.o_valid, e.rgb, e.idx, e.bg, e.vld);
        end
        checks++;
        assert ({bus.o_frame_done, bus.o_collision_mask, bus.o_player_collide} === {e.done, e.mask, e.player})
        else begin
            fails++;
            $error("FAIL %s frame: got done=%0b mask=%02h pc=%0b, want done=%0b mask=%02h pc=%0b",
                   e.tag, bus.o_frame_done, bus.o_collision_mask, bus.o_player_collide,
                   e.done, e.mask, e.player);
        end
    endtask

    task automatic drive_idle();
        bus.i_layer_hit = '0;
        bus.i_layer_en  = '0;
        bus.i_pix_valid = 1'b0;
        bus.i_v_sync    = 1'b0;
        bus.i_layer_rgb = '0;
        bus.i_bg_rgb    = '0;
        bus.i_key_en    = 1'b0;
        bus.i_key_rgb   = '0;
    endtask

    task automatic step(input string tag, input logic [NL-1:0] hit, input logic [NL-1:0] en,
                        input logic vld, input logic vs);
        exp_t e;
        logic [NL-1:0] q;
        logic [NL-1:0] contrib;
        logic [NL*RW-1:0] packed_rgb;
        @(negedge clk);
        check_front();
        for (int k = 0; k < NL; k++) packed_rgb[k*RW +: RW] = lrgb[k];
        bus.i_layer_rgb = packed_rgb;
        bus.i_layer_hit = hit;
        bus.i_layer_en  = en;
        bus.i_pix_valid = vld;
        bus.i_v_sync    = vs;
        bus.i_bg_rgb    = bg_rgb;
        bus.i_key_en    = key_en;
        bus.i_key_rgb   = key_rgb;

        for (int k = 0; k < NL; k++)
            q[k] = hit[k] && en[k] && !(key_en && lrgb[k] == key_rgb);
        e.bg  = 1'b1;
        e.idx = '0;
        e.rgb = bg_rgb;
        for (int k = NL - 1; k >= 0; k--) begin
            if (q[k]) begin
                e.bg  = 1'b0;
                e.idx = IW'(k);
                e.rgb = lrgb[k];
            end
        end
        e.vld = vld;
        contrib = (vld && $countones(q) >= 2) ? q : '0;
        if (vs && !m_prev_vs) begin
            m_mask   = m_acc | contrib;
            m_player = m_mask[PL];
            m_acc    = '0;
            e.done   = 1'b1;
        end else begin
            m_acc  = m_acc | contrib;
            e.done = 1'b0;
        end
        m_prev_vs = vs;
        e.mask    = m_mask;
        e.player  = m_player;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        check_zero(tag);
        sb.delete();
        m_acc = '0; m_mask = '0; m_player = 1'b0; m_prev_vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive_idle();
        key_en  = 1'b0;
        key_rgb = KEY_RGB_DEF;
        bg_rgb  = 24'h0000AA;
        for (int k = 0; k < NL; k++) lrgb[k] = {8'(k * 16 + 1), 8'(k * 8 + 3), 8'(255 - k)};
        lrgb[2] = 24'h112233;
        lrgb[5] = 24'h5A5A5A;

        rst_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Priority and background
        step("l2_l5_hit",   8'h24, 8'hFF, 1'b1, 1'b0);
        step("no_hit_bg",   8'h00, 8'hFF, 1'b1, 1'b0);
        step("l2_disabled", 8'h24, 8'hFB, 1'b1, 1'b0);
        step("all_hit",     8'hFF, 8'hFF, 1'b1, 1'b0);
        step("l7_only",     8'h80, 8'hFF, 1'b1, 1'b0);

        // Colour key: layer 0 transparent, layer 3 wins, no collision
        key_en  = 1'b1;
        lrgb[0] = 24'hFF00FF;
        lrgb[3] = 24'h00FF00;
        step("keyed_l0",    8'h09, 8'hFF, 1'b1, 1'b0);
        key_en  = 1'b0;
        lrgb[0] = 24'hA0B0C0;

        // Invalid pixel: composite still shown, overlap not counted
        step("invalid_pix", 8'h18, 8'hFF, 1'b0, 1'b0);

        // Close first frame (held v_sync -> single pulse)
        for (int i = 0; i < 4; i++) step("vs_hold", 8'h00, 8'hFF, 1'b1, 1'b1);
        step("vs_low", 8'h00, 8'hFF, 1'b1, 1'b0);

        // Layers 4 and 6 overlap for 10 pixels -> 0x50, player collides
        for (int i = 0; i < 10; i++) step("l4_l6", 8'h50, 8'hFF, 1'b1, 1'b0);
        step("l4_single", 8'h10, 8'hFF, 1'b1, 1'b0);
        step("close_50",  8'h00, 8'hFF, 1'b1, 1'b1);
        step("hold_50",   8'h00, 8'hFF, 1'b1, 1'b1);
        step("vs_low2",   8'h00, 8'hFF, 1'b1, 1'b0);

        // Empty frame reports 0
        for (int i = 0; i < 3; i++) step("empty", 8'h04, 8'hFF, 1'b1, 1'b0);
        step("close_00", 8'h00, 8'hFF, 1'b1, 1'b1);
        step("vs_low3",  8'h00, 8'hFF, 1'b1, 1'b0);

        // Overlap 1,7 in the rising edge cycle belongs to the closing frame
        step("pre_edge",  8'h02, 8'hFF, 1'b1, 1'b0);
        step("edge_1_7",  8'h82, 8'hFF, 1'b1, 1'b1);
        step("post_edge", 8'h00, 8'hFF, 1'b1, 1'b1);
        step("vs_low4",   8'h40, 8'hFF, 1'b1, 1'b0);
        step("close_ex",  8'h00, 8'hFF, 1'b1, 1'b1);

        // Glitchy v_sync: one pulse per rising edge
        step("glitch_lo", 8'h00, 8'hFF, 1'b1, 1'b0);
        step("glitch_hi", 8'h00, 8'hFF, 1'b1, 1'b1);
        step("glitch_lo", 8'h00, 8'hFF, 1'b1, 1'b0);
        step("glitch_lo", 8'h00, 8'hFF, 1'b1, 1'b0);

        // Reset mid-frame after collisions
        for (int i = 0; i < 3; i++) step("pre_rst", 8'h50, 8'hFF, 1'b1, 1'b0);
        async_reset("mid_reset");
        step("post_rst", 8'h0C, 8'hFF, 1'b1, 1'b0);
        step("post_rst", 8'h0C, 8'hFF, 1'b1, 1'b0);
        step("post_rst", 8'h00, 8'hFF, 1'b1, 1'b0);
        step("close_0c", 8'h00, 8'hFF, 1'b1, 1'b1);
        step("vs_low5",  8'h00, 8'hFF, 1'b1, 1'b0);
        step("drain",    8'h00, 8'hFF, 1'b1, 1'b0);
        step("drain",    8'h00, 8'hFF, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
